// File: rtl/affinex_pkg.sv
// Shared definitions for the affinex 2D affine transform peripheral:
// register addresses, STATUS bit positions, bus width codes, FSM states,
// arithmetic widths and the partial-write merge helper.
package affinex_pkg;

  localparam int unsigned FRAC_BITS = 8;   // Q8.8 coefficients
  localparam int unsigned ACC_W     = 34;  // signed accumulator width

  localparam logic [5:0] ADDR_AB     = 6'h00;
  localparam logic [5:0] ADDR_CD     = 6'h04;
  localparam logic [5:0] ADDR_T      = 6'h08;
  localparam logic [5:0] ADDR_IN     = 6'h0C;
  localparam logic [5:0] ADDR_OUT    = 6'h10;
  localparam logic [5:0] ADDR_STATUS = 6'h14;

  localparam int unsigned ST_BUSY = 0;
  localparam int unsigned ST_DONE = 1;
  localparam int unsigned ST_OVF  = 2;
  localparam int unsigned ST_ERR  = 3;
  localparam int unsigned ST_IE   = 4;

  localparam logic [1:0] WR_BYTE  = 2'b00;
  localparam logic [1:0] WR_HALF  = 2'b01;
  localparam logic [1:0] WR_WORD  = 2'b10;
  localparam logic [1:0] BUS_IDLE = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AX,
    S_BY,
    S_CX,
    S_DY
  } state_e;

  // Byte/half writes replace only the low bytes of a register.
  function automatic logic [31:0] merge_write(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [1:0]  wn);
    case (wn)
      WR_BYTE: return {old_v[31:8], new_v[7:0]};
      WR_HALF: return {old_v[31:16], new_v[15:0]};
      default: return new_v;
    endcase
  endfunction

endpackage

// File: rtl/affinex_mac.sv
// Combinational multiply-accumulate step for affinex_core.
//   coef, operand : signed 16-bit multiplier inputs
//   base          : value added to the product (sign-extended offset or running acc)
//   acc           : base + coef*operand, ACC_W-bit signed
//   sat           : acc >>> FRAC_BITS clamped to signed 16 bits
//   ovf           : 1 when the clamp was applied
module affinex_mac
  import affinex_pkg::*;
(
  input  logic [15:0]      coef,
  input  logic [15:0]      operand,
  input  logic [ACC_W-1:0] base,
  output logic [ACC_W-1:0] acc,
  output logic [15:0]      sat,
  output logic             ovf
);

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -(ACC_W'(32768));

  logic signed [31:0]      prod;
  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    prod    = $signed(coef) * $signed(operand);
    acc     = base + {{(ACC_W-32){prod[31]}}, prod};
    shifted = $signed(acc) >>> FRAC_BITS;
    ovf     = 1'b0;
    sat     = shifted[15:0];
    if (shifted > SAT_MAX) begin
      sat = 16'h7FFF;
      ovf = 1'b1;
    end else if (shifted < SAT_MIN) begin
      sat = 16'h8000;
      ovf = 1'b1;
    end
  end

endmodule

// File: rtl/affinex_core.sv
// TinyQV peripheral computing x' = A*x + B*y + TX, y' = C*x + D*y + TY on a
// single shared multiplier, one product per cycle (4 cycles per transform).
//   clk, rst        : clock, synchronous active-high reset
//   ui_in           : unused
//   address         : byte address, word-aligned registers only
//   data_in         : write data
//   data_write_n    : 11 idle, 00 byte, 01 half, 10 word write
//   data_read_n     : 11 idle, otherwise read request held until data_ready
//   data_out        : read data while data_ready
//   data_ready      : read complete (stalled for OUT reads while busy)
//   user_interrupt  : DONE & IE
//   uo_out          : {5'b0, OVF, user_interrupt, BUSY}
module affinex_core
  import affinex_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ui_in,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt,
  output logic [7:0]  uo_out
);

  state_e state_q, state_d;
  logic [31:0] ab_q, ab_d, cd_q, cd_d, t_q, t_d, in_q, in_d, out_q, out_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [15:0] xp_q, xp_d;
  logic done_q, done_d, ovf_q, ovf_d, err_q, err_d, ie_q, ie_d;

  logic [15:0]      mac_coef, mac_operand, mac_sat;
  logic [ACC_W-1:0] mac_base, mac_acc;
  logic             mac_ovf;
  logic             busy, wr_act, rd_act;
  logic [31:0]      rd_data;
  logic             unused_inputs;

  assign unused_inputs = ^ui_in;
  assign busy   = (state_q != S_IDLE);
  assign wr_act = (data_write_n != BUS_IDLE) && (address[1:0] == 2'b00);
  assign rd_act = (data_read_n != BUS_IDLE);

  affinex_mac u_mac (
    .coef    (mac_coef),
    .operand (mac_operand),
    .base    (mac_base),
    .acc     (mac_acc),
    .sat     (mac_sat),
    .ovf     (mac_ovf)
  );

  // Operand selection: the first step of each output loads the sign-extended
  // translation, the second accumulates onto the stored partial sum.
  always_comb begin
    mac_coef    = '0;
    mac_operand = '0;
    mac_base    = '0;
    case (state_q)
      S_AX: begin
        mac_coef = ab_q[15:0];  mac_operand = in_q[15:0];
        mac_base = {{(ACC_W-16){t_q[15]}}, t_q[15:0]};
      end
      S_BY: begin
        mac_coef = ab_q[31:16]; mac_operand = in_q[31:16]; mac_base = acc_q;
      end
      S_CX: begin
        mac_coef = cd_q[15:0];  mac_operand = in_q[15:0];
        mac_base = {{(ACC_W-16){t_q[31]}}, t_q[31:16]};
      end
      S_DY: begin
        mac_coef = cd_q[31:16]; mac_operand = in_q[31:16]; mac_base = acc_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ab_d = ab_q;  cd_d = cd_q;  t_d = t_q;  in_d = in_q;  out_d = out_q;
    acc_d = acc_q;  xp_d = xp_q;
    done_d = done_q;  ovf_d = ovf_q;  err_d = err_q;  ie_d = ie_q;

    // Bus writes are applied first so that FSM flag sets below win over W1C.
    if (wr_act) begin
      if (address == ADDR_STATUS) begin
        done_d = done_q & ~data_in[ST_DONE];
        ovf_d  = ovf_q  & ~data_in[ST_OVF];
        err_d  = err_q  & ~data_in[ST_ERR];
        ie_d   = data_in[ST_IE];
      end else if (address <= ADDR_OUT) begin
        if (busy) begin
          err_d = 1'b1;
        end else begin
          case (address)
            ADDR_AB: ab_d = merge_write(ab_q, data_in, data_write_n);
            ADDR_CD: cd_d = merge_write(cd_q, data_in, data_write_n);
            ADDR_T:  t_d  = merge_write(t_q, data_in, data_write_n);
            ADDR_IN: begin
              in_d = merge_write(in_q, data_in, data_write_n);
              if (data_write_n == WR_WORD) state_d = S_AX;
            end
            default: ;
          endcase
        end
      end
    end

    case (state_q)
      S_AX: begin acc_d = mac_acc; state_d = S_BY; end
      S_BY: begin
        acc_d   = mac_acc;
        xp_d    = mac_sat;
        ovf_d   = ovf_d | mac_ovf;
        state_d = S_CX;
      end
      S_CX: begin acc_d = mac_acc; state_d = S_DY; end
      S_DY: begin
        acc_d   = mac_acc;
        out_d   = {mac_sat, xp_q};
        ovf_d   = ovf_d | mac_ovf;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ab_q <= '0;  cd_q <= '0;  t_q <= '0;  in_q <= '0;  out_q <= '0;
      acc_q <= '0;  xp_q <= '0;
      done_q <= 1'b0;  ovf_q <= 1'b0;  err_q <= 1'b0;  ie_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ab_q <= ab_d;  cd_q <= cd_d;  t_q <= t_d;  in_q <= in_d;  out_q <= out_d;
      acc_q <= acc_d;  xp_q <= xp_d;
      done_q <= done_d;  ovf_q <= ovf_d;  err_q <= err_d;  ie_q <= ie_d;
    end
  end

  always_comb begin
    rd_data = '0;
    case (address)
      ADDR_AB:     rd_data = ab_q;
      ADDR_CD:     rd_data = cd_q;
      ADDR_T:      rd_data = t_q;
      ADDR_IN:     rd_data = in_q;
      ADDR_OUT:    rd_data = out_q;
      ADDR_STATUS: rd_data = {27'b0, ie_q, err_q, ovf_q, done_q, busy};
      default:     rd_data = '0;
    endcase
  end

  // OUT reads stall while a transform is running and complete with the new result.
  assign data_ready     = rd_act && !((address == ADDR_OUT) && busy);
  assign data_out       = data_ready ? rd_data : '0;
  assign user_interrupt = done_q & ie_q;
  assign uo_out         = {5'b0, ovf_q, user_interrupt, busy};

endmodule

// File: tb/tb_affinex_core.sv
module tb_affinex_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ui_in;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;
  logic [7:0]  uo_out;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [31:0] mon_e;
  string       mon_n;
  int          lowc;

  always #5 clk = ~clk;

  affinex_core dut (
    .clk            (clk),
    .rst            (rst),
    .ui_in          (ui_in),
    .address        (address),
    .data_in        (data_in),
    .data_write_n   (data_write_n),
    .data_read_n    (data_read_n),
    .data_out       (data_out),
    .data_ready     (data_ready),
    .user_interrupt (user_interrupt),
    .uo_out         (uo_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Monitor: every completed read pops the oldest expected value.
  always @(negedge clk) begin
    if (data_read_n != 2'b11 && data_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_read: got %h want none", data_out);
      end else begin
        mon_e = exp_q.pop_front();
        mon_n = name_q.pop_front();
        check(mon_n, data_out, mon_e);
      end
    end
  end

  task automatic bus_write(input logic [5:0] addr, input logic [31:0] data, input logic [1:0] wn);
    @(posedge clk); #1;
    address = addr; data_in = data; data_write_n = wn;
    @(posedge clk); #1;
    data_write_n = 2'b11;
  endtask

  task automatic bus_read(input logic [5:0] addr, input logic [31:0] exp, input string name,
                          output int low);
    bit got = 1'b0;
    low = 0;
    @(posedge clk); #1;
    address = addr; data_read_n = 2'b10;
    exp_q.push_back(exp);
    name_q.push_back(name);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (data_ready === 1'b1) got = 1'b1;
      else low++;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no data_ready want data_ready within 20 cycles", name);
      void'(exp_q.pop_front());
      void'(name_q.pop_front());
    end
    @(posedge clk); #1;
    data_read_n = 2'b11;
  endtask

  task automatic rd(input logic [5:0] addr, input logic [31:0] exp, input string name);
    int dummy;
    bus_read(addr, exp, name, dummy);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ui_in = '0; address = '0; data_in = '0;
    data_write_n = 2'b11; data_read_n = 2'b11;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_uo_out", {24'b0, uo_out}, 32'h0);
    check("reset_irq", {31'b0, user_interrupt}, 32'h0);
    check("reset_ready", {31'b0, data_ready}, 32'h0);
    rd(6'h14, 32'h0, "reset_status");
    rd(6'h10, 32'h0, "reset_out");
    rd(6'h00, 32'h0, "reset_ab");

    // Partial writes, misaligned writes, unmapped reads
    bus_write(6'h00, 32'h11223344, 2'b10);
    bus_write(6'h00, 32'hAABBCCDD, 2'b00);
    rd(6'h00, 32'h112233DD, "byte_write");
    bus_write(6'h00, 32'h5555EEFF, 2'b01);
    rd(6'h00, 32'h1122EEFF, "half_write");
    bus_write(6'h01, 32'hDEADBEEF, 2'b10);
    rd(6'h00, 32'h1122EEFF, "misaligned_write");
    rd(6'h18, 32'h0, "unmapped_read");
    bus_write(6'h0C, 32'h00000055, 2'b00);
    @(negedge clk);
    check("byte_in_no_start", {31'b0, uo_out[0]}, 32'h0);

    // Test 1: identity plus translation, busy exactly 4 cycles
    bus_write(6'h00, 32'h00000100, 2'b10);
    bus_write(6'h04, 32'h01000000, 2'b10);
    bus_write(6'h08, 32'hFD000500, 2'b10);
    bus_write(6'h0C, 32'h0014000A, 2'b10);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("t1_busy_c%0d", i), {31'b0, uo_out[0]}, (i < 4) ? 32'h1 : 32'h0);
    end
    rd(6'h10, 32'h0011000F, "t1_out");
    rd(6'h14, 32'h00000002, "t1_status");
    bus_write(6'h14, 32'h00000002, 2'b10);

    // Test 2 + 4: rotation; OUT read issued mid-transform stalls 3 cycles
    bus_write(6'h00, 32'hFF000000, 2'b10);
    bus_write(6'h04, 32'h00000100, 2'b10);
    bus_write(6'h08, 32'h00000000, 2'b10);
    bus_write(6'h0C, 32'h00040003, 2'b10);
    bus_read(6'h10, 32'h0003FFFC, "t2_out_stalled", lowc);
    check("t4_stall_cycles", lowc, 32'd3);
    rd(6'h0C, 32'h00040003, "t2_in_readback");
    bus_write(6'h14, 32'h00000002, 2'b10);

    // Test 3: saturation sets OVF, W1C clears only OVF
    bus_write(6'h00, 32'h00007FFF, 2'b10);
    bus_write(6'h04, 32'h00000000, 2'b10);
    bus_write(6'h0C, 32'h00007FFF, 2'b10);
    repeat (4) @(posedge clk);
    rd(6'h10, 32'h00007FFF, "t3_out_sat");
    rd(6'h14, 32'h00000006, "t3_status_ovf");
    check("t3_uo_ovf", {31'b0, uo_out[2]}, 32'h1);
    bus_write(6'h14, 32'h00000004, 2'b10);
    rd(6'h14, 32'h00000002, "t3_status_w1c");

    // Test 5: interrupt enable; W1C DONE in the completion cycle loses
    bus_write(6'h14, 32'h00000012, 2'b10);
    rd(6'h14, 32'h00000010, "t5_ie_only");
    bus_write(6'h0C, 32'h00007FFF, 2'b10);
    @(posedge clk);
    @(posedge clk);
    bus_write(6'h14, 32'h00000012, 2'b10);
    check("t5_irq", {31'b0, user_interrupt}, 32'h1);
    check("t5_uo_irq", {31'b0, uo_out[1]}, 32'h1);
    rd(6'h14, 32'h00000016, "t5_status_set_wins");
    bus_write(6'h14, 32'h00000016, 2'b10);
    rd(6'h14, 32'h00000010, "t5_status_cleared");
    check("t5_irq_cleared", {31'b0, user_interrupt}, 32'h0);

    // Test 6: write during busy is discarded and flags ERR
    bus_write(6'h0C, 32'h00007FFF, 2'b10);
    bus_write(6'h00, 32'h12345678, 2'b10);
    repeat (4) @(posedge clk);
    rd(6'h00, 32'h00007FFF, "t6_a_unchanged");
    rd(6'h14, 32'h0000001E, "t6_status_err");
    rd(6'h10, 32'h00007FFF, "t6_out_unaffected");

    // Reset in S_CX aborts the transform and clears everything
    bus_write(6'h0C, 32'h00010001, 2'b10);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t6_rst_uo_out", {24'b0, uo_out}, 32'h0);
    check("t6_rst_irq", {31'b0, user_interrupt}, 32'h0);
    rd(6'h10, 32'h0, "t6_rst_out");
    rd(6'h14, 32'h0, "t6_rst_status");
    rd(6'h00, 32'h0, "t6_rst_ab");
    rd(6'h08, 32'h0, "t6_rst_t");

    // Clean restart after reset
    bus_write(6'h00, 32'h00000100, 2'b10);
    bus_write(6'h04, 32'h01000000, 2'b10);
    bus_write(6'h08, 32'hFD000500, 2'b10);
    bus_write(6'h0C, 32'h0014000A, 2'b10);
    repeat (4) @(posedge clk);
    rd(6'h10, 32'h0011000F, "t6_restart_out");
    rd(6'h14, 32'h00000002, "t6_restart_status");

    repeat (2) @(posedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
